// File: rtl/ifetch.sv
// ============================================================================
//  Module   : ifetch
//  Purpose  : Byte-serial instruction fetch. Collects four little-endian
//             bytes from the memory controller into one 32-bit word, then
//             holds it until the decoder can take it. Supports flush
//             redirects and a global ready/freeze input.
//  Options  : IFETCH_JAL_PREDICT_EN - when defined, a completed JAL word
//             redirects the next fetch to its target instead of pc + 4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_byte,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        ifetch_todo,
  output logic [31:0] ifetch_inst,
  output logic [31:0] ifetch_pc
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic [31:0] w_next_pc;

`ifdef IFETCH_JAL_PREDICT_EN
  localparam logic [6:0] c_OPCODE_JAL = 7'b1101111;

  logic [31:0] w_jal_imm;

  // Sign-extended J-type immediate of the held word
  assign w_jal_imm = {{11{r_word[31]}}, r_word[31], r_word[19:12],
                      r_word[20], r_word[30:21], 1'b0};

  // Follow a JAL target directly; everything else falls through
  assign w_next_pc = (r_word[6:0] == c_OPCODE_JAL) ? (r_pc + w_jal_imm)
                                                    : (r_pc + 32'd4);
`else
  // Sequential fetch only
  assign w_next_pc = r_pc + 32'd4;
`endif

  // Memory request side: fetch byte pc + byte_cnt while collecting
  assign mem_req  = (r_state == FETCH);
  assign mem_addr = r_pc + {30'd0, r_cnt};

  // Issue pulse: only from HOLD, only when enabled, not stalled, not flushed
  assign ifetch_todo = rdy_in && !flush_in && !stall_in && (r_state == HOLD);
  assign ifetch_inst = r_word;
  assign ifetch_pc   = r_pc;

  // Fetch/hold state machine with byte assembly; flush has top priority
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= FETCH;
      r_pc    <= 32'd0;
      r_cnt   <= 2'd0;
      r_word  <= 32'd0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_state <= FETCH;
        r_pc    <= flush_pc;
        r_cnt   <= 2'd0;
        r_word  <= 32'd0;
      end else begin
        case (r_state)
          FETCH: begin
            if (mem_ack) begin
              case (r_cnt)
                2'd0:    r_word[7:0]   <= mem_byte;
                2'd1:    r_word[15:8]  <= mem_byte;
                2'd2:    r_word[23:16] <= mem_byte;
                default: r_word[31:24] <= mem_byte;
              endcase
              r_cnt <= r_cnt + 2'd1;
              if (r_cnt == 2'd3) begin
                r_state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall_in) begin
              r_pc    <= w_next_pc;
              r_state <= FETCH;
            end
          end
          default: begin
            r_state <= FETCH;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
